lc3_imem_responder: RTL

//  Instruction-memory responder on the far end of the fetch stage's memory read interface.
//  - Samples pc/instrmem_rd and returns the addressed instruction word after LATENCY cycles,

---
 rtl/lc3_imem_pkg.sv | 29 ++
 rtl/lc3_imem_array.sv | 37 +++
 rtl/lc3_imem_responder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lc3_imem_pkg.sv
// ----------------------------------------------------------------------------
// lc3_imem_pkg
//   Shared types and constants for the LC-3 instruction-memory responder.
//   - IMEM_DEPTH_DEF : default number of memory words
//   - IMEM_LAT_MAX   : largest supported request-to-valid latency
//   - imem_word_t    : one instruction word
//   - imem_stage_t   : one read-pipeline stage {valid, data, par}
//   Optional feature macro used by the responder: IMEM_PARITY_EN
// ----------------------------------------------------------------------------
package lc3_imem_pkg;

    localparam int IMEM_DEPTH_DEF = 256;
    localparam int IMEM_LAT_MAX   = 4;
    localparam int IMEM_DATA_W    = 16;

    typedef logic [IMEM_DATA_W-1:0] imem_word_t;

    typedef struct packed {
        logic       valid;
        imem_word_t data;
        logic       par;
    } imem_stage_t;

    // Even parity: the stored bit makes the XOR of word plus bit zero.
    function automatic logic imem_par(input imem_word_t w);
        return ^w;
    endfunction

endpackage

// File: rtl/lc3_imem_array.sv
// ----------------------------------------------------------------------------
// lc3_imem_array
//   1-write / 1-read memory. Writes land on the rising edge; the read port is
//   asynchronous, so a consumer that registers o_rd_data on the same edge as a
//   write to the same index captures the OLD word.
//   Ports:
//     i_clk      clock
//     i_wr_en    write strobe
//     i_wr_idx   write index
//     i_wr_data  write word
//     i_rd_idx   read index
//     o_rd_data  word currently stored at i_rd_idx
// ----------------------------------------------------------------------------
module lc3_imem_array #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 256,
    parameter int IW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [IW-1:0]     i_wr_idx,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic [IW-1:0]     i_rd_idx,
    output logic [WORD_W-1:0] o_rd_data
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/lc3_imem_responder.sv
// ----------------------------------------------------------------------------
// lc3_imem_responder
//   Instruction-memory responder for the LC-3 fetch stage. A read request
//   sampled on a rising edge returns the addressed word LATENCY cycles later
//   with a one-cycle dout_valid strobe. flush squashes every in-flight read
//   while still accepting a request presented in the same cycle. A backdoor
//   write port preloads program images.
//   Optional feature: define IMEM_PARITY_EN to store an even-parity bit per
//   word and report mismatches on parity_err (adds input force_par_flip).
//   Ports:
//     clock, reset          rising-edge clock, synchronous active-high reset
//     pc, instrmem_rd       fetch address and read request
//     flush                 squash in-flight reads
//     wr_en/wr_addr/wr_data backdoor write
//     force_par_flip        (IMEM_PARITY_EN only) corrupt parity of this write
//     dout, dout_valid      returned word and its strobe
//     busy                  reads outstanding
//     parity_err            parity mismatch on the returned word
// ----------------------------------------------------------------------------
module lc3_imem_responder
    import lc3_imem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = IMEM_DATA_W,
    parameter int DEPTH   = IMEM_DEPTH_DEF,
    parameter int LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              instrmem_rd,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
`ifdef IMEM_PARITY_EN
    input  logic              force_par_flip,
`endif
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              parity_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1) + 1;
`ifdef IMEM_PARITY_EN
    localparam int MW = DATA_W + 1;
`else
    localparam int MW = DATA_W;
`endif

    if (LATENCY < 1 || LATENCY > IMEM_LAT_MAX) begin : g_bad_latency
        $error("lc3_imem_responder: LATENCY must be in 1..4");
    end
    if (DATA_W != IMEM_DATA_W) begin : g_bad_width
        $error("lc3_imem_responder: DATA_W must match imem_word_t");
    end

    logic [MW-1:0] w_wr_word;
    logic [MW-1:0] w_rd_word;
    imem_stage_t   w_in;
    imem_stage_t   w_last;
    logic          w_last_vld;
    logic          w_unused;

    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_parity_err;
    logic [CW-1:0]     r_cnt;

`ifdef IMEM_PARITY_EN
    assign w_wr_word = {imem_par(wr_data) ^ force_par_flip, wr_data};
    assign w_in.par  = w_rd_word[DATA_W];
`else
    assign w_wr_word = wr_data;
    assign w_in.par  = 1'b0;
`endif
    assign w_in.valid = instrmem_rd;
    assign w_in.data  = w_rd_word[DATA_W-1:0];

    // Only the low index bits address the array; upper address bits wrap.
    lc3_imem_array #(
        .WORD_W (MW),
        .DEPTH  (DEPTH),
        .IW     (IW)
    ) u_array (
        .i_clk     (clock),
        .i_wr_en   (wr_en),
        .i_wr_idx  (wr_addr[IW-1:0]),
        .i_wr_data (w_wr_word),
        .i_rd_idx  (pc[IW-1:0]),
        .o_rd_data (w_rd_word)
    );

    // Stage 1 is captured on the accept edge; with LATENCY=1 that capture is
    // the output register itself, otherwise stages 1..LATENCY-1 shift here and
    // the output register is the final stage.
    if (LATENCY == 1) begin : g_direct
        assign w_last     = w_in;
        assign w_last_vld = instrmem_rd;
    end else begin : g_pipe
        imem_stage_t r_stg [LATENCY-1];

        always_ff @(posedge clock) begin
            r_stg[0] <= w_in;
            for (int k = 1; k < LATENCY - 1; k++) begin
                r_stg[k] <= r_stg[k-1];
            end
            // A flush kills older stages but the request sampled now survives.
            if (flush) begin
                for (int k = 1; k < LATENCY - 1; k++) begin
                    r_stg[k].valid <= 1'b0;
                end
            end
            if (reset) begin
                for (int k = 0; k < LATENCY - 1; k++) begin
                    r_stg[k].valid <= 1'b0;
                end
            end
        end

        assign w_last     = r_stg[LATENCY-2];
        assign w_last_vld = r_stg[LATENCY-2].valid && !flush;
    end

    // A request stays outstanding until the edge after its strobe, so the
    // registered strobe doubles as the retire pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_dout_valid <= w_last_vld;
            if (w_last_vld) begin
                r_dout <= w_last.data;
            end
`ifdef IMEM_PARITY_EN
            r_parity_err <= w_last_vld && (imem_par(w_last.data) != w_last.par);
`else
            r_parity_err <= 1'b0;
`endif
            if (flush) begin
                r_cnt <= instrmem_rd ? CW'(1) : '0;
            end else begin
                r_cnt <= r_cnt + CW'(instrmem_rd) - CW'(r_dout_valid);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (r_cnt <= CW'(LATENCY));
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = (r_cnt != '0);
    assign parity_err = r_parity_err;

    assign w_unused = ^{1'b0, pc[ADDR_W-1:IW], wr_addr[ADDR_W-1:IW], w_last.par};

endmodule
